// File: rtl/leaf_port_rx_buffer_pkg.sv
// BFT packet field layout, packet struct and credit FSM encoding shared by the
// leaf-port receive buffer files.
package leaf_port_rx_buffer_pkg;

    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;

    localparam int VALID_BIT = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;

    typedef struct packed {
        logic                     vld;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } bft_pkt_t;

    typedef enum logic {
        CR_IDLE = 1'b0,
        CR_SEND = 1'b1
    } credit_state_t;

endpackage

// File: rtl/leaf_port_rx_buffer_if.sv
// Downstream payload stream plus credit-return channel of the leaf-port receive
// buffer; master is the buffer, slave is the kernel side / credit consumer.
interface leaf_port_rx_buffer_if;
    import leaf_port_rx_buffer_pkg::*;

    logic [PAYLOAD_BITS-1:0] dout;
    logic                    vld_out;
    logic                    rdy_downward;
    logic [PACKET_BITS-1:0]  credit_pkt;
    logic                    credit_vld;
    logic                    credit_ack;

    modport master (
        output dout, vld_out, credit_pkt, credit_vld,
        input  rdy_downward, credit_ack
    );

    modport slave (
        input  dout, vld_out, credit_pkt, credit_vld,
        output rdy_downward, credit_ack
    );

endinterface

// File: rtl/leaf_port_rx_buffer_sync_fifo_fwft.sv
// Purpose: first-word-fall-through FIFO with registered head word and occupancy count.
// Latency: a word pushed into an empty FIFO at edge t appears on dout/vld after edge t+1.
// Backpressure: pushes when full are ignored unless a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_BITS = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  vld,
    output logic [DEPTH_BITS:0]   count,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0]   ONE     = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr;
    logic [DEPTH_BITS-1:0] rd_ptr_nxt;
    logic                  push_ok;

    assign full       = (count == (DEPTH_BITS+1)'(DEPTH));
    assign push_ok    = push && (!full || pop);
    assign rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Head register reloads every cycle from the post-pop read pointer; a word
    // written this edge is only visible one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= 1'b0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_ptr_nxt;
            unique case ({push_ok, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            vld  <= (count > ONE) || ((count == ONE) && !pop);
            dout <= mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/leaf_port_rx_buffer.sv
// Purpose: filter BFT packets for MY_PORT, queue payloads, return credits per drained block.
// Latency: accepted packet reaches vld_out two edges later when the FIFO was empty.
// Backpressure: none upstream (full drops + sticky overflow); downstream valid/ready; credit held until ack.
module leaf_port_rx_buffer
    import leaf_port_rx_buffer_pkg::*;
#(
    parameter int MY_PORT               = 2,
    parameter int FIFO_DEPTH_BITS       = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    input  logic [PACKET_BITS-1:0]     din_leaf_bft2interface,
    input  logic [NUM_LEAF_BITS-1:0]   src_leaf,
    leaf_port_rx_buffer_if.master      bus,
    output logic                       overflow,
    output logic [FIFO_DEPTH_BITS:0]   fifo_count
);

    localparam logic [FIFO_DEPTH_BITS:0] THRESH = (FIFO_DEPTH_BITS+1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [FIFO_DEPTH_BITS:0] ZERO_W = '0;

    bft_pkt_t                  pkt;
    bft_pkt_t                  credit_q;
    bft_pkt_t                  credit_nxt;
    logic                      unused_fields;
    logic                      match;
    logic                      started;
    logic                      fifo_vld;
    logic                      fifo_full;
    logic [PAYLOAD_BITS-1:0]   fifo_dout;
    logic                      vld_out;
    logic                      pop;
    logic [FIFO_DEPTH_BITS:0]  freed;
    logic [FIFO_DEPTH_BITS:0]  freed_inc;
    logic [FIFO_DEPTH_BITS:0]  freed_nxt;
    logic                      load_credit;
    credit_state_t             state;
    credit_state_t             state_nxt;

    assign pkt           = din_leaf_bft2interface;
    assign unused_fields = ^{pkt.leaf, pkt.addr};
    assign match         = pkt.vld && (pkt.port == NUM_PORT_BITS'(MY_PORT));

    assign vld_out = fifo_vld && started;
    assign pop     = vld_out && bus.rdy_downward;

    sync_fifo_fwft #(
        .WIDTH      (PAYLOAD_BITS),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (match),
        .push_dat (pkt.payload),
        .pop      (pop),
        .dout     (fifo_dout),
        .vld      (fifo_vld),
        .count    (fifo_count),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ap_start) begin
                started <= 1'b1;
            end
            if (match && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign credit_nxt = '{vld: 1'b1, leaf: src_leaf, port: NUM_PORT_BITS'(MY_PORT),
                          addr: '0, payload: PAYLOAD_BITS'(freed)};
    assign freed_inc  = freed + {ZERO_W[FIFO_DEPTH_BITS:1], pop};

    always_comb begin
        state_nxt   = state;
        load_credit = 1'b0;
        freed_nxt   = freed_inc;
        unique case (state)
            CR_IDLE: begin
                if (freed >= THRESH) begin
                    // Report everything freed so far; only this cycle's pop carries over.
                    load_credit = 1'b1;
                    freed_nxt   = freed_inc - freed;
                    state_nxt   = CR_SEND;
                end
            end
            CR_SEND: begin
                if (bus.credit_ack) begin
                    state_nxt = CR_IDLE;
                end
            end
            default: state_nxt = CR_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CR_IDLE;
            freed    <= '0;
            credit_q <= '0;
        end else begin
            state <= state_nxt;
            freed <= freed_nxt;
            if (load_credit) begin
                credit_q <= credit_nxt;
            end
        end
    end

    assign bus.dout       = fifo_dout;
    assign bus.vld_out    = vld_out;
    assign bus.credit_pkt = credit_q;
    assign bus.credit_vld = (state == CR_SEND);

endmodule

// File: tb/tb_leaf_port_rx_buffer.sv
// Directed and randomized bench for leaf_port_rx_buffer against a queue-based reference model.
module tb_leaf_port_rx_buffer;
    import leaf_port_rx_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ap_start;
    logic [48:0] din;
    logic [4:0]  src_leaf;
    logic        overflow;
    logic [7:0]  fifo_count;

    leaf_port_rx_buffer_if bus();

    leaf_port_rx_buffer #(
        .MY_PORT               (2),
        .FIFO_DEPTH_BITS       (7),
        .FREESPACE_UPDATE_SIZE (64)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ap_start               (ap_start),
        .din_leaf_bft2interface (din),
        .src_leaf               (src_leaf),
        .bus                    (bus),
        .overflow               (overflow),
        .fifo_count             (fifo_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q[$];
    bit          m_started, m_vld, m_ovf, m_send;
    logic [7:0]  m_freed;
    logic [48:0] m_pkt;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [48:0] mk(input logic v, input logic [3:0] port, input logic [31:0] pay);
        logic [4:0] lf = 5'($urandom);
        logic [6:0] ad = 7'($urandom);
        return {v, lf, port, ad, pay};
    endfunction

    task automatic check_all();
        chk("vld_out", 64'(bus.vld_out), 64'(m_vld));
        if (m_vld) chk("dout", 64'(bus.dout), 64'(q[0]));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("credit_vld", 64'(bus.credit_vld), 64'(m_send));
        if (m_send) chk("credit_pkt", 64'(bus.credit_pkt), 64'(m_pkt));
    endtask

    task automatic model_clear();
        q.delete();
        m_started = 0; m_vld = 0; m_ovf = 0; m_send = 0;
        m_freed = 0; m_pkt = '0;
    endtask

    // Asserted away from any clock edge, outputs are checked before the next edge.
    task automatic do_reset(input string tag);
        din = '0; bus.rdy_downward = 0; bus.credit_ack = 0; ap_start = 0;
        reset = 1;
        #1;
        model_clear();
        chk({tag, "_vld"}, 64'(bus.vld_out), 64'(0));
        chk({tag, "_count"}, 64'(fifo_count), 64'(0));
        chk({tag, "_credit_vld"}, 64'(bus.credit_vld), 64'(0));
        chk({tag, "_dout"}, 64'(bus.dout), 64'(0));
        chk({tag, "_credit_pkt"}, 64'(bus.credit_pkt), 64'(0));
        chk({tag, "_ovf"}, 64'(overflow), 64'(0));
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic step(input logic [48:0] d, input logic r, input logic a, input logic s);
        bit pop, match, full_b, pushed;
        din = d; bus.rdy_downward = r; bus.credit_ack = a; ap_start = s;
        pop    = m_vld && r;
        match  = d[48] && (d[42:39] == 4'd2);
        full_b = (q.size() == 128);
        @(posedge clk);
        #1;
        pushed = 0;
        if (pop) void'(q.pop_front());
        if (match) begin
            if (!full_b || pop) begin
                q.push_back(d[31:0]);
                pushed = 1;
            end else begin
                m_ovf = 1;
            end
        end
        m_started = m_started || s;
        m_vld = m_started && ((q.size() - int'(pushed)) > 0);
        if (!m_send) begin
            if (m_freed >= 8'd64) begin
                m_pkt   = {1'b1, src_leaf, 4'd2, 7'd0, 24'd0, m_freed};
                m_freed = 8'(pop);
                m_send  = 1;
            end else begin
                m_freed = m_freed + 8'(pop);
            end
        end else begin
            if (a) m_send = 0;
            m_freed = m_freed + 8'(pop);
        end
        check_all();
    endtask

    initial begin
        logic [48:0] p;
        logic [3:0]  prt;
        src_leaf = 5'd3;
        do_reset("rst0");

        // Single packet end to end
        p = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
        step(p, 1, 0, 1);
        chk("t1_count_after_push", 64'(fifo_count), 64'(1));
        step('0, 1, 0, 1);
        chk("t1_vld", 64'(bus.vld_out), 64'(1));
        chk("t1_dout", 64'(bus.dout), 64'(32'hDEADBEEF));
        step('0, 1, 0, 1);
        chk("t1_count_drained", 64'(fifo_count), 64'(0));

        // Wrong port or invalid packets never enqueue
        for (int i = 0; i < 20; i++) begin
            prt = 4'($urandom_range(0, 15));
            if (prt == 4'd2) prt = 4'd1;
            if (i % 2 == 0) step(mk(1, prt, $urandom), 1, 0, 1);
            else            step(mk(0, 4'd2, $urandom), 1, 0, 1);
        end
        chk("t2_count", 64'(fifo_count), 64'(0));

        // ap_start gating
        do_reset("rst1");
        for (int i = 0; i < 3; i++) step(mk(1, 4'd2, $urandom), 1, 0, 0);
        step('0, 1, 0, 0);
        chk("t3_vld_gated", 64'(bus.vld_out), 64'(0));
        chk("t3_count", 64'(fifo_count), 64'(3));
        for (int i = 0; i < 5; i++) step('0, 1, 0, 1);
        chk("t3_drained", 64'(fifo_count), 64'(0));

        // Fill past full, push+pop at full, then credit generation
        do_reset("rst2");
        src_leaf = 5'($urandom);
        for (int i = 0; i < 130; i++) step(mk(1, 4'd2, $urandom), 0, 0, 1);
        chk("t4_count_full", 64'(fifo_count), 64'(128));
        chk("t4_overflow", 64'(overflow), 64'(1));
        step(mk(1, 4'd2, $urandom), 1, 0, 1);
        chk("t4_count_pushpop", 64'(fifo_count), 64'(128));
        for (int i = 0; i < 64; i++) step('0, 1, 0, 1);
        chk("t4_credit_vld", 64'(bus.credit_vld), 64'(1));
        chk("t4_credit_payload", 64'(bus.credit_pkt[31:0]), 64'(64));
        chk("t4_credit_port", 64'(bus.credit_pkt[42:39]), 64'(2));
        for (int i = 0; i < 64; i++) step('0, 1, 0, 1);
        step('0, 0, 1, 1);
        step('0, 0, 0, 1);
        chk("t4_credit2_vld", 64'(bus.credit_vld), 64'(1));

        // Asynchronous reset while a credit is pending with words queued
        do_reset("rst3");
        for (int i = 0; i < 74; i++) step(mk(1, 4'd2, $urandom), 0, 0, 1);
        for (int i = 0; i < 64; i++) step('0, 1, 0, 1);
        step('0, 0, 0, 1);
        chk("t5_in_send", 64'(bus.credit_vld), 64'(1));
        chk("t5_queued", 64'(fifo_count), 64'(10));
        do_reset("t5_async");

        // Randomized traffic: slow drain first (fills/overflows), then fast drain
        src_leaf = 5'($urandom);
        for (int i = 0; i < 1500; i++) begin
            logic v, r, a, s;
            v   = ($urandom_range(0, 3) != 0);
            prt = ($urandom_range(0, 1) == 1) ? 4'd2 : 4'($urandom);
            r   = (i < 500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 8);
            a   = ($urandom_range(0, 3) == 0);
            s   = (i >= 20) ? 1'b1 : ($urandom_range(0, 7) == 0);
            step(mk(v, prt, $urandom), r, a, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
